// File: rtl/if_fetch_unit.sv
// Instruction-fetch front end: owns the PC, handshakes with instruction memory,
// buffers one returned word and strobes it into the decode-side instruction register.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic        IR_Write,
  output logic [31:0] inst_out,
  output logic [31:0] pc_out,
  output logic        misalign_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    HOLD  = 2'd3
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] pc, pc_nxt;
  logic [31:0] fetch_addr, fetch_addr_nxt;
  logic [31:0] buf_data, buf_data_nxt;
  logic [31:0] buf_pc, buf_pc_nxt;
  logic        err_nxt;
  logic [31:0] target;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

  assign target = word_align(redirect_pc);

  always_comb begin
    state_nxt      = state;
    pc_nxt         = pc;
    fetch_addr_nxt = fetch_addr;
    buf_data_nxt   = buf_data;
    buf_pc_nxt     = buf_pc;
    err_nxt        = misalign_err | (redirect & (redirect_pc[1:0] != 2'b00));
    imem_req       = 1'b0;
    imem_addr      = pc;
    IR_Write       = 1'b0;

    case (state)
      IDLE: begin
        state_nxt = FETCH;
        if (redirect) pc_nxt = target;
      end
      FETCH: begin
        imem_req       = 1'b1;
        fetch_addr_nxt = pc;
        if (redirect) begin
          // Data arriving alongside a redirect belongs to the wrong path.
          pc_nxt = target;
          if (!imem_ready) state_nxt = DRAIN;
        end else if (imem_ready) begin
          buf_data_nxt = imem_rdata;
          buf_pc_nxt   = pc;
          pc_nxt       = pc + 32'd4;
          state_nxt    = HOLD;
        end
      end
      DRAIN: begin
        // Keep presenting the abandoned address until memory completes it.
        imem_req  = 1'b1;
        imem_addr = fetch_addr;
        if (redirect) pc_nxt = target;
        if (imem_ready) state_nxt = FETCH;
      end
      HOLD: begin
        IR_Write = !stall && !redirect;
        if (redirect) begin
          pc_nxt    = target;
          state_nxt = FETCH;
        end else if (!stall) begin
          state_nxt = FETCH;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      pc           <= RESET_PC;
      fetch_addr   <= 32'h0;
      buf_data     <= 32'h0;
      buf_pc       <= 32'h0;
      misalign_err <= 1'b0;
    end else begin
      state        <= state_nxt;
      pc           <= pc_nxt;
      fetch_addr   <= fetch_addr_nxt;
      buf_data     <= buf_data_nxt;
      buf_pc       <= buf_pc_nxt;
      misalign_err <= err_nxt;
    end
  end

  assign inst_out = buf_data;
  assign pc_out   = buf_pc;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: a memory model answers addr^0xA5A5_0000 with
// programmable wait states; a monitor scores every IR_Write against a queue.
module tb_if_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        IR_Write;
  logic [31:0] inst_out;
  logic [31:0] pc_out;
  logic        misalign_err;

  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          wait_n = 0;
  int          wcnt = 0;
  logic        spurious = 1'b0;
  logic [63:0] exp_q[$];
  int          strobe_q[$];
  logic [63:0] mon_e;
  int          exp_cyc[10] = '{3, 5, 7, 13, 19, 21, 26, 29, 32, 3};

  always #5 clk = ~clk;

  if_fetch_unit #(.RESET_PC(32'h0000_0100)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ready  (imem_ready),
    .imem_rdata  (imem_rdata),
    .IR_Write    (IR_Write),
    .inst_out    (inst_out),
    .pc_out      (pc_out),
    .misalign_err(misalign_err)
  );

  // Memory: ready after wait_n idle request cycles; spurious forces a stray pulse.
  assign imem_ready = spurious | (imem_req && (wcnt == wait_n));
  assign imem_rdata = imem_addr ^ 32'hA5A5_0000;

  // cyc = 1 in the cycle following a reset edge.
  always @(posedge clk) begin
    cyc  <= rst_n ? cyc + 1 : 1;
    wcnt <= (!imem_req || imem_ready) ? 0 : wcnt + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic go(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  always @(negedge clk) begin
    if (IR_Write === 1'b1) begin
      strobe_q.push_back(cyc);
      if (exp_q.size() == 0) begin
        chk("unexpected_strobe_pc", pc_out, 32'hDEAD_BEEF);
      end else begin
        mon_e = exp_q.pop_front();
        chk("deliver_pc", pc_out, mon_e[63:32]);
        chk("deliver_inst", inst_out, mon_e[31:0]);
      end
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req", imem_req, 0);
    chk("rst_irw", IR_Write, 0);
    chk("rst_inst", inst_out, 0);
    chk("rst_pc_out", pc_out, 0);
    chk("rst_err", misalign_err, 0);

    exp_q.push_back({32'h0000_0100, 32'hA5A5_0100});
    exp_q.push_back({32'h0000_0104, 32'hA5A5_0104});
    exp_q.push_back({32'h0000_0108, 32'hA5A5_0108});
    exp_q.push_back({32'h0000_010C, 32'hA5A5_010C});
    rst_n = 1'b1;
    #1 chk("idle_req", imem_req, 0);
    go(2);
    #1 chk("first_req", imem_req, 1);
    chk("first_addr", imem_addr, 32'h0000_0100);

    // Stall for four HOLD cycles with a stray ready in the middle.
    go(9);
    stall = 1'b1;
    for (int c = 9; c <= 12; c++) begin
      go(c);
      spurious = (c == 10);
      #1;
      chk("stall_req", imem_req, 0);
      chk("stall_irw", IR_Write, 0);
      chk("stall_inst", inst_out, 32'hA5A5_010C);
    end
    spurious = 1'b0;
    go(13);
    stall = 1'b0;
    wait_n = 3;

    // Redirect while a 3-wait fetch of 0x110 is outstanding.
    go(15);
    redirect = 1'b1;
    redirect_pc = 32'h0000_0200;
    exp_q.push_back({32'h0000_0200, 32'hA5A5_0200});
    exp_q.push_back({32'h0000_0204, 32'hA5A5_0204});
    go(16);
    redirect = 1'b0;
    #1 chk("drain_req", imem_req, 1);
    chk("drain_addr", imem_addr, 32'h0000_0110);
    go(17);
    #1 chk("drain_addr_hold", imem_addr, 32'h0000_0110);
    go(18);
    wait_n = 0;
    #1 chk("post_drain_addr", imem_addr, 32'h0000_0200);

    // Redirect coinciding with ready in FETCH.
    go(22);
    redirect = 1'b1;
    redirect_pc = 32'h0000_0300;
    go(23);
    redirect = 1'b0;
    #1 chk("same_cycle_addr", imem_addr, 32'h0000_0300);

    // Redirect during a stalled HOLD drops the buffered word.
    go(24);
    stall = 1'b1;
    redirect = 1'b1;
    redirect_pc = 32'h0000_0400;
    exp_q.push_back({32'h0000_0400, 32'hA5A5_0400});
    go(25);
    stall = 1'b0;
    redirect = 1'b0;
    #1 chk("hold_redir_addr", imem_addr, 32'h0000_0400);
    chk("err_clear", misalign_err, 0);

    // Misaligned redirect target.
    go(27);
    redirect = 1'b1;
    redirect_pc = 32'h0000_0206;
    exp_q.push_back({32'h0000_0204, 32'hA5A5_0204});
    go(28);
    redirect = 1'b0;
    #1 chk("misalign_addr", imem_addr, 32'h0000_0204);
    chk("misalign_set", misalign_err, 1);

    // PC wrap from the top of the address space, then reset mid-fetch.
    go(30);
    redirect = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    exp_q.push_back({32'hFFFF_FFFC, 32'h5A5A_FFFC});
    go(31);
    redirect = 1'b0;
    #1 chk("top_addr", imem_addr, 32'hFFFF_FFFC);
    go(32);
    wait_n = 3;
    go(33);
    #1 chk("wrap_addr", imem_addr, 32'h0000_0000);
    chk("wrap_req", imem_req, 1);
    chk("misalign_sticky", misalign_err, 1);
    go(34);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("mid_rst_req", imem_req, 0);
    chk("mid_rst_irw", IR_Write, 0);
    chk("mid_rst_inst", inst_out, 0);
    chk("mid_rst_pc_out", pc_out, 0);
    chk("mid_rst_err", misalign_err, 0);

    exp_q.push_back({32'h0000_0100, 32'hA5A5_0100});
    wait_n = 0;
    rst_n = 1'b1;
    go(2);
    #1 chk("restart_addr", imem_addr, 32'h0000_0100);
    go(5);
    stall = 1'b1;
    go(10);

    chk("queue_drained", exp_q.size(), 0);
    chk("strobe_count", strobe_q.size(), 10);
    for (int i = 0; i < 10; i++) begin
      if (i < strobe_q.size()) chk("strobe_cycle", strobe_q[i], exp_cyc[i]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
